spi_frame_rx: RTL and testbench
===============================

# spi_frame_rx

Parametrised SPI slave receiver for the sensor-input path. It captures serial frames of configurable length in any of the four SPI modes, MSB- or LSB-first. Back-to-back words within one enable window are supported. Completed words are handed to the core through a registered valid/ready interface, with overrun and truncated-frame reporting. It replaces the fixed single-frame receiver and sits between the external SPI pins and the input buffer.

## Interface
- DATA_WIDTH, 2: bits per sample.
- DATA_DEPTH, 16: samples per word; word length W = DATA_WIDTH*DATA_DEPTH (≥2).
- SYNC_DEPTH, 2: flops per input synchroniser (≥2); identical for clk, en and data so that all three stay aligned.
- clk  input  1  system clock.
- nrst  input  1  asynchronous, active-low reset.
- spi_clk  input  1  async serial clock.
- spi_en  input  1  async frame enable, active high.
- spi_data  input  1  async serial data.
- cpol  input  1  clock polarity; latched at spi_en rising edge.
- cpha  input  1  clock phase; latched at spi_en rising edge.
- msb_first  input  1  1 = first bit is word MSB; latched at spi_en rising edge.
- word_ready  input  1  consumer accepts word_data this cycle.
- word_valid  output  1  word_data holds an unconsumed word.
- word_data  output  W  received word.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: spi_en fell with a partial word.
- busy  output  1  synchronised spi_en is high (receiving).

## Operation
- All three async inputs pass through SYNC_DEPTH synchronisers. Edge detection works on the synchronised signals only.
- State machine:
  - IDLE → RECV on synchronised spi_en rising edge. On that edge: latch cpol/cpha/msb_first, clear bit counter and shift register.
  - RECV → IDLE on synchronised spi_en falling edge.
- Sample edge:
  - Rising synchronised spi_clk when latched cpol == cpha (modes 0, 3).
  - Falling otherwise (modes 1, 2).
- Sample edges in IDLE are ignored.
- On each sample edge in RECV, shift in synchronised spi_data and increment the counter (width $clog2(W+1)):
  - msb_first = 1: shift left, new bit enters bit 0.
  - msb_first = 0: shift right, new bit enters bit W-1.
- Word completion happens when the counter reaches W:
  - Word is pushed to the output stage and the counter resets to 0 in the same cycle.
  - Reception continues within the same enable window (burst). There is no dead cycle between words.
- Output stage, single registered entry:
  - Push with word_valid = 0: load word_data, set word_valid.
  - Push with word_valid = 1 and word_ready = 1 in the same cycle: load the new word, word_valid stays 1 (simultaneous pop+push).
  - Push with word_valid = 1 and word_ready = 0: new word discarded, word_data unchanged, overrun pulses.
  - word_ready with no push: clear word_valid. word_data keeps its last value.
- spi_en falls with counter ≠ 0: frame_err pulses, partial bits are discarded, no push. With counter = 0: no error.
- spi_en falling on the same cycle as a completing sample edge: the sample is taken, the word is pushed, no frame_err.
- Mode inputs changing during RECV have no effect until the next enable rising edge.

## Timing
- Reset values: word_valid 0, word_data 0, overrun 0, frame_err 0, busy 0, state IDLE, counter 0, latched mode 0/0/1.
- Each spi_clk high and low phase must be ≥ 2 clk periods. spi_data must be stable ≥ 2 clk before and after the sample edge.
- Latency: the pin edge reaches the synchroniser output after SYNC_DEPTH clk, and the edge pulse follows 1 clk later. The shift/counter update happens on that pulse cycle. word_valid rises on the next clk edge, i.e. SYNC_DEPTH+2 clk after the pin-level final sample edge.
- overrun and frame_err: single-cycle pulses, registered, asserted on the cycle word_valid would otherwise update.
- busy follows synchronised spi_en, delayed 1 clk.
- Reset mid-frame: all state clears immediately. Reception restarts only after a fresh spi_en rising edge, so a reset while spi_en is held high ignores the remaining bits of that window.

## Test plan
- Mode 0, msb_first = 1, W = 32, send 0xDEADBEEF, word_ready = 1 → word_valid pulses 1 cycle with word_data = 0xDEADBEEF; overrun/frame_err stay 0.
- Mode 3, msb_first = 0, send bit sequence of 0x0000_00A5 LSB-first → word_data = 0x000000A5. Repeat in modes 1 and 2 with the same result.
- Burst of 0x12345678 then 0x9ABCDEF0 in one enable window, word_ready held 0 → word_data = 0x12345678, word_valid = 1, one overrun pulse. Then word_ready = 1 for one cycle → word_valid = 0.
- Burst of two words with word_ready = 1 asserted on the second push cycle → word_data = 0x9ABCDEF0, word_valid stays 1, no overrun.
- 5 bits, then spi_en low → frame_err pulses once, word_valid stays 0. The next full frame 0x0F0F0F0F is received correctly.
- nrst low after 20 bits, spi_en held high, 12 more bits, spi_en low/high, full frame 0xCAFEF00D → all outputs 0 during the rest of the interrupted window. The next frame gives word_data = 0xCAFEF00D.

Source files
------------

// File: rtl/spi_frame_rx.sv
// SPI slave receiver: synchronises the SPI pins, assembles words of configurable length in any SPI mode,
// and hands completed words to the core through a single registered valid/ready entry.
module spi_frame_rx #(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned DATA_DEPTH = 16,
   parameter int unsigned SYNC_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               spi_clk,
   input  logic                               spi_en,
   input  logic                               spi_data,
   input  logic                               cpol,
   input  logic                               cpha,
   input  logic                               msb_first,
   input  logic                               word_ready,
   output logic                               word_valid,
   output logic [DATA_WIDTH*DATA_DEPTH-1:0]   word_data,
   output logic                               overrun,
   output logic                               frame_err,
   output logic                               busy
);

   localparam int unsigned WORD_W = DATA_WIDTH * DATA_DEPTH;
   localparam int unsigned CNT_W  = $clog2(WORD_W + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   // synchroniser chains
   logic [SYNC_DEPTH-1:0] r_clk_sync;
   logic [SYNC_DEPTH-1:0] r_en_sync;
   logic [SYNC_DEPTH-1:0] r_data_sync;
   logic                  w_clk_s;
   logic                  w_en_s;
   logic                  w_data_s;

   // edge detection
   logic r_clk_prev;
   logic r_en_prev;
   logic r_clk_rise;
   logic r_clk_fall;
   logic r_en_rise;
   logic r_en_fall;
   logic r_data_q;
   logic r_armed;

   // frame state
   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [WORD_W-1:0]  r_shift;
   logic [WORD_W-1:0]  w_shift_next;
   logic               r_cpol;
   logic               r_cpha;
   logic               r_msb;
   logic               w_latch;
   logic               w_sample;
   logic               w_push;
   logic               w_frame_err;

   // output stage
   logic               r_valid;
   logic [WORD_W-1:0]  r_word;
   logic               r_overrun;
   logic               r_frame_err;
   logic               r_busy;
   logic               w_load;
   logic               w_overrun;

   assign w_clk_s  = r_clk_sync[SYNC_DEPTH-1];
   assign w_en_s   = r_en_sync[SYNC_DEPTH-1];
   assign w_data_s = r_data_sync[SYNC_DEPTH-1];

   // The enable chain resets high so a reset inside an active window cannot fake a rising edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_clk_sync  <= '0;
         r_en_sync   <= '1;
         r_data_sync <= '0;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_DEPTH-2:0], spi_clk};
         r_en_sync   <= {r_en_sync[SYNC_DEPTH-2:0], spi_en};
         r_data_sync <= {r_data_sync[SYNC_DEPTH-2:0], spi_data};
      end
   end

   // Registered edge pulses; data is delayed by the same stage so it stays aligned with them.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_clk_prev <= 1'b0;
         r_en_prev  <= 1'b1;
         r_clk_rise <= 1'b0;
         r_clk_fall <= 1'b0;
         r_en_rise  <= 1'b0;
         r_en_fall  <= 1'b0;
         r_data_q   <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_clk_prev <= w_clk_s;
         r_en_prev  <= w_en_s;
         r_clk_rise <= w_clk_s & ~r_clk_prev;
         r_clk_fall <= ~w_clk_s & r_clk_prev;
         r_en_rise  <= w_en_s & ~r_en_prev;
         r_en_fall  <= ~w_en_s & r_en_prev;
         r_data_q   <= w_data_s;
         r_armed    <= r_armed | ~w_en_s;
      end
   end

   assign w_sample = (r_cpol == r_cpha) ? r_clk_rise : r_clk_fall;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and shift/count datapath; a completing sample wins over a simultaneous enable fall.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_push       = 1'b0;
      w_frame_err  = 1'b0;
      w_latch      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_en_rise) begin
               w_state_next = S_RECV;
               w_latch      = 1'b1;
               w_cnt_next   = '0;
               w_shift_next = '0;
            end
         end
         S_RECV: begin
            if (w_sample) begin
               if (r_msb) begin
                  w_shift_next = {r_shift[WORD_W-2:0], r_data_q};
               end else begin
                  w_shift_next = {r_data_q, r_shift[WORD_W-1:1]};
               end
               if (r_cnt == CNT_W'(WORD_W - 1)) begin
                  w_push     = 1'b1;
                  w_cnt_next = '0;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
            if (r_en_fall) begin
               w_state_next = S_IDLE;
               w_frame_err  = (w_cnt_next != '0);
               w_cnt_next   = '0;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt  <= '0;
         r_shift <= '0;
         r_cpol <= 1'b0;
         r_cpha <= 1'b0;
         r_msb  <= 1'b1;
      end else begin
         r_cnt   <= w_cnt_next;
         r_shift <= w_shift_next;
         if (w_latch) begin
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_msb  <= msb_first;
         end
      end
   end

   assign w_load    = w_push & (~r_valid | word_ready);
   assign w_overrun = w_push & r_valid & ~word_ready;

   // Single-entry output register with simultaneous pop+push and drop-on-full.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_valid     <= 1'b0;
         r_word      <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         if (w_load) begin
            r_valid <= 1'b1;
            r_word  <= w_shift_next;
         end else if (word_ready) begin
            r_valid <= 1'b0;
         end
         r_overrun   <= w_overrun;
         r_frame_err <= w_frame_err;
         r_busy      <= w_en_s & r_armed;
      end
   end

   assign word_valid = r_valid;
   assign word_data  = r_word;
   assign overrun    = r_overrun;
   assign frame_err  = r_frame_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: drives SPI frames in all modes and scoreboards accepted words,
// pulse counts and reset behaviour.
module tb_spi_frame_rx;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         spi_clk = 1'b0;
   logic         spi_en = 1'b0;
   logic         spi_data = 1'b0;
   logic         cpol = 1'b0;
   logic         cpha = 1'b0;
   logic         msb_first = 1'b1;
   logic         word_ready = 1'b0;
   logic         word_valid;
   logic [W-1:0] word_data;
   logic         overrun;
   logic         frame_err;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int n_ovr = 0;
   int n_ferr = 0;
   int n_vcyc = 0;
   int n_quiet = 0;
   bit quiet = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;

   always #5 clk = ~clk;

   spi_frame_rx #(
      .DATA_WIDTH(2),
      .DATA_DEPTH(16),
      .SYNC_DEPTH(2)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .spi_clk   (spi_clk),
      .spi_en    (spi_en),
      .spi_data  (spi_data),
      .cpol      (cpol),
      .cpha      (cpha),
      .msb_first (msb_first),
      .word_ready(word_ready),
      .word_valid(word_valid),
      .word_data (word_data),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted word and tallies pulses.
   always @(negedge clk) begin
      if (nrst && word_valid === 1'b1 && word_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", word_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("word_data", word_data, mon_exp);
         end
      end
      if (overrun === 1'b1) n_ovr++;
      if (frame_err === 1'b1) n_ferr++;
      if (word_valid === 1'b1) n_vcyc++;
      if (quiet && (word_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 ||
                    busy !== 1'b0 || word_data !== '0)) n_quiet++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic half();
      repeat (4) tick();
   endtask

   task automatic frame_begin(input logic pol, input logic pha, input logic msb);
      cpol      = pol;
      cpha      = pha;
      msb_first = msb;
      spi_clk   = pol;
      half();
      spi_en = 1'b1;
      repeat (6) tick();
   endtask

   task automatic frame_end();
      half();
      spi_en = 1'b0;
      repeat (10) tick();
   endtask

   // One bit per SPI period; optionally pulses word_ready exactly on the push cycle of the last bit.
   task automatic send_bits(input logic [W-1:0] w, input int n, input bit rdy_on_push);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = msb_first ? w[W-1-i] : w[i];
         if (!cpha) begin
            spi_data = b;
            half();
            spi_clk = ~spi_clk;
         end else begin
            spi_clk  = ~spi_clk;
            spi_data = b;
            half();
            spi_clk = ~spi_clk;
         end
         if (rdy_on_push && i == n - 1) begin
            repeat (3) tick();
            word_ready = 1'b1;
            tick();
            word_ready = 1'b0;
         end else begin
            half();
         end
         if (!cpha) spi_clk = ~spi_clk;
      end
   endtask

   int v0, o0, f0;
   logic pols[3] = '{1'b1, 1'b0, 1'b1};
   logic phas[3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      repeat (3) tick();
      nrst = 1'b1;
      tick();
      chk("rst_valid", W'(word_valid), '0);
      chk("rst_data", word_data, '0);
      chk("rst_overrun", W'(overrun), '0);
      chk("rst_frame_err", W'(frame_err), '0);
      chk("rst_busy", W'(busy), '0);

      // mode 0, MSB first, consumer always ready
      word_ready = 1'b1;
      v0 = n_vcyc; o0 = n_ovr; f0 = n_ferr;
      exp_q.push_back(32'hDEADBEEF);
      frame_begin(1'b0, 1'b0, 1'b1);
      chk("t1_busy", W'(busy), 32'd1);
      send_bits(32'hDEADBEEF, 32, 1'b0);
      frame_end();
      chk("t1_valid_cycles", W'(n_vcyc - v0), 32'd1);
      chk("t1_overrun", W'(n_ovr - o0), 32'd0);
      chk("t1_frame_err", W'(n_ferr - f0), 32'd0);
      chk("t1_pending", W'(exp_q.size()), 32'd0);
      chk("t1_busy_end", W'(busy), 32'd0);

      // modes 3, 1, 2 with LSB first
      for (int m = 0; m < 3; m++) begin
         exp_q.push_back(32'h000000A5);
         frame_begin(pols[m], phas[m], 1'b0);
         send_bits(32'h000000A5, 32, 1'b0);
         frame_end();
         chk("t2_pending", W'(exp_q.size()), 32'd0);
      end

      // burst with consumer stalled: second word dropped
      word_ready = 1'b0;
      o0 = n_ovr; f0 = n_ferr;
      exp_q.push_back(32'h12345678);
      frame_begin(1'b0, 1'b0, 1'b1);
      send_bits(32'h12345678, 32, 1'b0);
      send_bits(32'h9ABCDEF0, 32, 1'b0);
      frame_end();
      chk("t3_data", word_data, 32'h12345678);
      chk("t3_valid", W'(word_valid), 32'd1);
      chk("t3_overrun", W'(n_ovr - o0), 32'd1);
      chk("t3_frame_err", W'(n_ferr - f0), 32'd0);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      tick();
      chk("t3_valid_after_pop", W'(word_valid), 32'd0);
      chk("t3_pending", W'(exp_q.size()), 32'd0);

      // burst with pop on the second push cycle
      o0 = n_ovr;
      exp_q.push_back(32'h12345678);
      exp_q.push_back(32'h9ABCDEF0);
      frame_begin(1'b0, 1'b0, 1'b1);
      send_bits(32'h12345678, 32, 1'b0);
      send_bits(32'h9ABCDEF0, 32, 1'b1);
      chk("t4_valid", W'(word_valid), 32'd1);
      chk("t4_data", word_data, 32'h9ABCDEF0);
      frame_end();
      chk("t4_overrun", W'(n_ovr - o0), 32'd0);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      tick();
      chk("t4_pending", W'(exp_q.size()), 32'd0);

      // truncated frame, then a good one
      f0 = n_ferr; v0 = n_vcyc;
      frame_begin(1'b0, 1'b0, 1'b1);
      send_bits(32'hFFFFFFFF, 5, 1'b0);
      frame_end();
      chk("t5_frame_err", W'(n_ferr - f0), 32'd1);
      chk("t5_valid_cycles", W'(n_vcyc - v0), 32'd0);
      word_ready = 1'b1;
      exp_q.push_back(32'h0F0F0F0F);
      frame_begin(1'b0, 1'b0, 1'b1);
      send_bits(32'h0F0F0F0F, 32, 1'b0);
      frame_end();
      chk("t5_pending", W'(exp_q.size()), 32'd0);
      chk("t5_frame_err_total", W'(n_ferr - f0), 32'd1);

      // reset in the middle of a window
      frame_begin(1'b0, 1'b0, 1'b1);
      send_bits(32'h11111111, 20, 1'b0);
      nrst  = 1'b0;
      quiet = 1'b1;
      repeat (3) tick();
      nrst = 1'b1;
      send_bits(32'h22222222, 12, 1'b0);
      half();
      spi_en = 1'b0;
      repeat (10) tick();
      quiet = 1'b0;
      chk("t6_quiet_violations", W'(n_quiet), 32'd0);
      exp_q.push_back(32'hCAFEF00D);
      frame_begin(1'b0, 1'b0, 1'b1);
      send_bits(32'hCAFEF00D, 32, 1'b0);
      frame_end();
      chk("t6_pending", W'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
